iat_stat_evaluator: RTL

//  Reader side of the per-second inter-arrival-time (IAT) flow statistics.

---
 rtl/iat_stat_evaluator.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/iat_stat_evaluator.sv
// ---------------------------------------------------------------------------
// iat_stat_evaluator
//   Reader side of the per-second inter-arrival-time flow statistics. Once per
//   window it captures suitable/total, computes ratio = floor(s*256/t) with a
//   9-step restoring divider (s clamped to t), and applies streak-based
//   hysteresis to drive use_ex.
//
//   Optional feature macro: IAT_EVAL_MINMAX_EN adds ratio_min/ratio_max
//   tracking and the clr_minmax input.
//
// Ports
//   asclk              clock
//   reset              synchronous, active-high
//   cnt_time           free-running window time counter (28 bits)
//   num_suitable_f_iat suitable-IAT count of the last window
//   num_total_f_iat    total-IAT count of the last window
//   ratio              last ratio, 0..256 (256 = 100 %)
//   ratio_valid        1-cycle pulse when ratio/use_ex update
//   use_ex             steering decision
//   err_overrun        sticky: window end seen while a division was running
//   clr_minmax         (IAT_EVAL_MINMAX_EN) restart min/max tracking
//   ratio_min/max      (IAT_EVAL_MINMAX_EN) extremes of ratio since clear
//
// Handshake: there is no back-pressure; ratio_valid is a single-cycle strobe
// and ratio/use_ex are stable from that cycle until the next strobe.
// ---------------------------------------------------------------------------
module iat_stat_evaluator #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned WINDOW_END = 160000000,
    parameter int unsigned HI_THRESH  = 192,
    parameter int unsigned LO_THRESH  = 128,
    parameter int unsigned HI_WINDOWS = 3,
    parameter int unsigned LO_WINDOWS = 2
) (
    input  logic             asclk,
    input  logic             reset,
    input  logic [27:0]      cnt_time,
    input  logic [CNT_W-1:0] num_suitable_f_iat,
    input  logic [CNT_W-1:0] num_total_f_iat,
`ifdef IAT_EVAL_MINMAX_EN
    input  logic             clr_minmax,
    output logic [8:0]       ratio_min,
    output logic [8:0]       ratio_max,
`endif
    output logic [8:0]       ratio,
    output logic             ratio_valid,
    output logic             use_ex,
    output logic             err_overrun
);

    typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, DECIDE = 2'd2} state_t;

    localparam logic [27:0] WIN_END = 28'(WINDOW_END);
    localparam logic [8:0]  HI_TH   = 9'(HI_THRESH);
    localparam logic [8:0]  LO_TH   = 9'(LO_THRESH);
    localparam logic [3:0]  HI_WIN  = 4'(HI_WINDOWS);
    localparam logic [3:0]  LO_WIN  = 4'(LO_WINDOWS);

    state_t           state, state_nxt;
    logic             win_end_d;
    logic [CNT_W:0]   rem;
    logic [CNT_W-1:0] t_reg;
    logic [8:0]       q;
    logic [3:0]       bit_cnt;
    logic [3:0]       hi_streak, lo_streak;
    logic [3:0]       hi_nxt, lo_nxt;
    logic             do_latch, do_div, do_decide;
    logic             q_bit;
    logic [CNT_W:0]   rem_sub;
    logic [CNT_W-1:0] s_clamp;

    // State register
    always_ff @(posedge asclk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; an empty window (total == 0) never leaves IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_end_d && (num_total_f_iat != '0)) state_nxt = DIV;
            DIV:     if (bit_cnt == 4'd8) state_nxt = DECIDE;
            DECIDE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output (control) logic
    always_comb begin
        do_latch  = 1'b0;
        do_div    = 1'b0;
        do_decide = 1'b0;
        case (state)
            IDLE:    do_latch  = win_end_d && (num_total_f_iat != '0);
            DIV:     do_div    = 1'b1;
            DECIDE:  do_decide = 1'b1;
            default: ;
        endcase
    end

    // Suitable beyond total would produce a quotient above 256; clamping keeps
    // the result within the 9 quotient bits.
    assign s_clamp = (num_suitable_f_iat > num_total_f_iat) ? num_total_f_iat
                                                            : num_suitable_f_iat;

    // One restoring step: rem stays below t after subtraction, so the left
    // shift never drops a set bit.
    assign q_bit   = (rem >= {1'b0, t_reg});
    assign rem_sub = q_bit ? (rem - {1'b0, t_reg}) : rem;

    // Streak update for the quotient being decided
    always_comb begin
        hi_nxt = 4'd0;
        lo_nxt = 4'd0;
        if (q >= HI_TH)      hi_nxt = (hi_streak == 4'd15) ? 4'd15 : hi_streak + 4'd1;
        else if (q < LO_TH)  lo_nxt = (lo_streak == 4'd15) ? 4'd15 : lo_streak + 4'd1;
    end

    always_ff @(posedge asclk) begin
        if (reset) begin
            win_end_d   <= 1'b0;
            rem         <= '0;
            t_reg       <= '0;
            q           <= '0;
            bit_cnt     <= '0;
            hi_streak   <= '0;
            lo_streak   <= '0;
            ratio       <= '0;
            ratio_valid <= 1'b0;
            use_ex      <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            win_end_d   <= (cnt_time == WIN_END);
            ratio_valid <= 1'b0;
            if (win_end_d && (state != IDLE)) err_overrun <= 1'b1;
            if (do_latch) begin
                rem     <= {1'b0, s_clamp};
                t_reg   <= num_total_f_iat;
                q       <= '0;
                bit_cnt <= '0;
            end
            if (do_div) begin
                rem     <= rem_sub << 1;
                q       <= {q[7:0], q_bit};
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (do_decide) begin
                hi_streak   <= hi_nxt;
                lo_streak   <= lo_nxt;
                ratio       <= q;
                ratio_valid <= 1'b1;
                if (hi_nxt >= HI_WIN)      use_ex <= 1'b1;
                else if (lo_nxt >= LO_WIN) use_ex <= 1'b0;
            end
        end
    end

`ifdef IAT_EVAL_MINMAX_EN
    // Tracks the published ratio the cycle after each strobe. A strobe in the
    // same cycle as clr_minmax wins and loads both extremes.
    logic mm_first;
    always_ff @(posedge asclk) begin
        if (reset) begin
            ratio_min <= '0;
            ratio_max <= '0;
            mm_first  <= 1'b1;
        end else if (ratio_valid) begin
            mm_first <= 1'b0;
            if (mm_first || clr_minmax) begin
                ratio_min <= ratio;
                ratio_max <= ratio;
            end else begin
                if (ratio < ratio_min) ratio_min <= ratio;
                if (ratio > ratio_max) ratio_max <= ratio;
            end
        end else if (clr_minmax) begin
            ratio_min <= 9'd256;
            ratio_max <= 9'd0;
            mm_first  <= 1'b1;
        end
    end
`endif

endmodule
